// File: rtl/univ_shift_reg.sv
// univ_shift_reg: WIDTH-bit register that can hold, load, shift, rotate and count.
//
// Ports:
//   clk     - rising-edge clock for all state updates
//   clrn    - synchronous active-high clear; loads RESET_VALUE and overrides en and mode
//   en      - clock enable; when low, q holds
//   mode    - operation select:
//             000 hold, 001 load, 010 shl, 011 shr,
//             100 rol,  101 ror,  110 count up, 111 count down
//   d       - parallel load data
//   sin_l   - serial input, enters at the MSB on shift right
//   sin_r   - serial input, enters at the LSB on shift left
//   q       - registered state
//   sout_l  - q[WIDTH-1]
//   sout_r  - q[0]
//   co      - carry/borrow out; high in the cycle before a count wraps
//   zero    - high when q == 0
module univ_shift_reg #(
    parameter int unsigned           WIDTH       = 8,
    parameter logic [WIDTH-1:0]      RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             sin_l,
    input  logic             sin_r,
    output logic [WIDTH-1:0] q,
    output logic             sout_l,
    output logic             sout_r,
    output logic             co,
    output logic             zero
);

    typedef enum logic [2:0] {
        MODE_HOLD  = 3'b000,
        MODE_LOAD  = 3'b001,
        MODE_SHL   = 3'b010,
        MODE_SHR   = 3'b011,
        MODE_ROL   = 3'b100,
        MODE_ROR   = 3'b101,
        MODE_CNTUP = 3'b110,
        MODE_CNTDN = 3'b111
    } mode_t;

    mode_t            op;
    logic [WIDTH-1:0] q_next;

    assign op = mode_t'(mode);

    always_comb begin
        q_next = q;
        case (op)
            MODE_HOLD:  q_next = q;
            MODE_LOAD:  q_next = d;
            MODE_SHL:   q_next = {q[WIDTH-2:0], sin_r};
            MODE_SHR:   q_next = {sin_l, q[WIDTH-1:1]};
            MODE_ROL:   q_next = {q[WIDTH-2:0], q[WIDTH-1]};
            MODE_ROR:   q_next = {q[0], q[WIDTH-1:1]};
            MODE_CNTUP: q_next = q + {{(WIDTH-1){1'b0}}, 1'b1};
            MODE_CNTDN: q_next = q - {{(WIDTH-1){1'b0}}, 1'b1};
            default:    q_next = q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clrn) begin
            q <= RESET_VALUE;
        end else if (en) begin
            q <= q_next;
        end
    end

    assign sout_l = q[WIDTH-1];
    assign sout_r = q[0];
    assign zero   = (q == '0);

    // Asserted before the wrap edge so a chained stage sees it as its enable
    // on the same edge the lower stage wraps; independent of clrn.
    assign co = en & (((op == MODE_CNTUP) & (q == '1)) |
                      ((op == MODE_CNTDN) & (q == '0)));

endmodule

// File: tb/tb_univ_shift_reg.sv
module tb_univ_shift_reg;

    logic       clk = 1'b0;
    int         checks = 0;
    int         errors = 0;

    // main instance, WIDTH=8, RESET_VALUE=0
    logic       clrn, en, sin_l, sin_r;
    logic [2:0] mode;
    logic [7:0] d;
    logic [7:0] q;
    logic       sout_l, sout_r, co, zero;

    // cascaded pair
    logic       c_clrn, c_en;
    logic [2:0] c_mode;
    logic [7:0] lo_q, hi_q;
    logic       lo_sl, lo_sr, lo_co, lo_z;
    logic       hi_sl, hi_sr, hi_co, hi_z;

    // instance with RESET_VALUE=8'h5A
    logic       r_clrn, r_en;
    logic [2:0] r_mode;
    logic [7:0] r_q;
    logic       r_sl, r_sr, r_co, r_z;

    always #5 clk = ~clk;

    univ_shift_reg #(.WIDTH(8), .RESET_VALUE(8'h00)) dut (
        .clk(clk), .clrn(clrn), .en(en), .mode(mode), .d(d),
        .sin_l(sin_l), .sin_r(sin_r), .q(q),
        .sout_l(sout_l), .sout_r(sout_r), .co(co), .zero(zero)
    );

    univ_shift_reg #(.WIDTH(8), .RESET_VALUE(8'h00)) u_lo (
        .clk(clk), .clrn(c_clrn), .en(c_en), .mode(c_mode), .d(8'h00),
        .sin_l(1'b0), .sin_r(1'b0), .q(lo_q),
        .sout_l(lo_sl), .sout_r(lo_sr), .co(lo_co), .zero(lo_z)
    );

    univ_shift_reg #(.WIDTH(8), .RESET_VALUE(8'h00)) u_hi (
        .clk(clk), .clrn(c_clrn), .en(lo_co), .mode(c_mode), .d(8'h00),
        .sin_l(1'b0), .sin_r(1'b0), .q(hi_q),
        .sout_l(hi_sl), .sout_r(hi_sr), .co(hi_co), .zero(hi_z)
    );

    univ_shift_reg #(.WIDTH(8), .RESET_VALUE(8'h5A)) u_rv (
        .clk(clk), .clrn(r_clrn), .en(r_en), .mode(r_mode), .d(8'h00),
        .sin_l(1'b0), .sin_r(1'b0), .q(r_q),
        .sout_l(r_sl), .sout_r(r_sr), .co(r_co), .zero(r_z)
    );

    // inputs change and outputs are sampled 1 time unit after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [7:0] val);
        clrn = 1'b0; en = 1'b1; mode = 3'b001; d = val;
        tick();
    endtask

    task automatic test_reset();
        clrn = 1'b1; en = 1'b0; mode = 3'b000; d = 8'h00; sin_l = 1'b0; sin_r = 1'b0;
        tick();
        checks++;
        if (q !== 8'h00) begin errors++; $display("FAIL reset_q: got %h expected %h", q, 8'h00); end
        checks++;
        if ({zero, sout_l, sout_r, co} !== 4'b1000) begin
            errors++; $display("FAIL reset_flags: got %b expected %b", {zero, sout_l, sout_r, co}, 4'b1000);
        end
    endtask

    task automatic test_reset_priority();
        load(8'hA5);
        checks++;
        if (q !== 8'hA5) begin errors++; $display("FAIL prio_load: got %h expected %h", q, 8'hA5); end
        clrn = 1'b1; en = 1'b1; mode = 3'b001; d = 8'hFF;
        tick();
        checks++;
        if (q !== 8'h00 || zero !== 1'b1) begin
            errors++; $display("FAIL prio_clr: got q=%h zero=%b expected q=00 zero=1", q, zero);
        end
        clrn = 1'b0;
        tick();
        checks++;
        if (q !== 8'hFF || zero !== 1'b0) begin
            errors++; $display("FAIL prio_reload: got q=%h zero=%b expected q=ff zero=0", q, zero);
        end
    endtask

    task automatic test_load_hold();
        load(8'h3C);
        checks++;
        if (q !== 8'h3C) begin errors++; $display("FAIL lh_load: got %h expected %h", q, 8'h3C); end
        en = 1'b0; mode = 3'b110;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (q !== 8'h3C) begin errors++; $display("FAIL lh_en0_%0d: got %h expected %h", i, q, 8'h3C); end
        end
        en = 1'b1; mode = 3'b000;
        tick();
        checks++;
        if (q !== 8'h3C) begin errors++; $display("FAIL lh_hold: got %h expected %h", q, 8'h3C); end
    endtask

    task automatic test_shifts();
        load(8'h81);
        checks++;
        if (sout_l !== 1'b1 || sout_r !== 1'b1) begin
            errors++; $display("FAIL sh_sout: got l=%b r=%b expected l=1 r=1", sout_l, sout_r);
        end
        mode = 3'b010; sin_r = 1'b1; sin_l = 1'b0;
        tick();
        checks++;
        if (q !== 8'h03) begin errors++; $display("FAIL shl: got %h expected %h", q, 8'h03); end

        load(8'h81);
        mode = 3'b011; sin_l = 1'b0; sin_r = 1'b1;
        tick();
        checks++;
        if (q !== 8'h40) begin errors++; $display("FAIL shr0: got %h expected %h", q, 8'h40); end

        load(8'h81);
        mode = 3'b011; sin_l = 1'b1; sin_r = 1'b0;
        tick();
        checks++;
        if (q !== 8'hC0) begin errors++; $display("FAIL shr1: got %h expected %h", q, 8'hC0); end

        load(8'h81);
        mode = 3'b100; sin_l = 1'b0; sin_r = 1'b0;
        tick();
        checks++;
        if (q !== 8'h03) begin errors++; $display("FAIL rol: got %h expected %h", q, 8'h03); end

        load(8'h81);
        mode = 3'b101; sin_l = 1'b0; sin_r = 1'b0;
        tick();
        checks++;
        if (q !== 8'hC0) begin errors++; $display("FAIL ror: got %h expected %h", q, 8'hC0); end

        load(8'hFF);
        mode = 3'b010; #1;
        checks++;
        if (co !== 1'b0) begin errors++; $display("FAIL co_shl_ones: got %b expected %b", co, 1'b0); end
        load(8'h00);
        mode = 3'b011; #1;
        checks++;
        if (co !== 1'b0) begin errors++; $display("FAIL co_shr_zero: got %b expected %b", co, 1'b0); end
    endtask

    task automatic test_count_wrap();
        load(8'hFE);
        mode = 3'b110; #1;
        checks++;
        if (co !== 1'b0) begin errors++; $display("FAIL up_co_fe: got %b expected %b", co, 1'b0); end
        tick();
        checks++;
        if (q !== 8'hFF || co !== 1'b1) begin
            errors++; $display("FAIL up_ff: got q=%h co=%b expected q=ff co=1", q, co);
        end
        tick();
        checks++;
        if (q !== 8'h00 || co !== 1'b0 || zero !== 1'b1) begin
            errors++; $display("FAIL up_wrap: got q=%h co=%b zero=%b expected q=00 co=0 zero=1", q, co, zero);
        end
        mode = 3'b111; #1;
        checks++;
        if (co !== 1'b1) begin errors++; $display("FAIL dn_co_00: got %b expected %b", co, 1'b1); end
        en = 1'b0; #1;
        checks++;
        if (co !== 1'b0) begin errors++; $display("FAIL dn_co_en0: got %b expected %b", co, 1'b0); end
        en = 1'b1; #1;
        tick();
        checks++;
        if (q !== 8'hFF || co !== 1'b0) begin
            errors++; $display("FAIL dn_wrap: got q=%h co=%b expected q=ff co=0", q, co);
        end
        tick();
        checks++;
        if (q !== 8'hFE) begin errors++; $display("FAIL dn_fe: got %h expected %h", q, 8'hFE); end
    endtask

    task automatic test_cascade();
        c_clrn = 1'b1; c_en = 1'b1; c_mode = 3'b110;
        tick();
        c_clrn = 1'b0;
        repeat (255) tick();
        checks++;
        if (lo_q !== 8'hFF || hi_q !== 8'h00 || lo_co !== 1'b1) begin
            errors++; $display("FAIL cas_pre: got lo=%h hi=%h co=%b expected lo=ff hi=00 co=1", lo_q, hi_q, lo_co);
        end
        tick();
        checks++;
        if (lo_q !== 8'h00 || hi_q !== 8'h01) begin
            errors++; $display("FAIL cas_carry: got lo=%h hi=%h expected lo=00 hi=01", lo_q, hi_q);
        end
        c_clrn = 1'b1;
        tick();
        c_clrn = 1'b0;
        repeat (65535) tick();
        checks++;
        if (lo_q !== 8'hFF || hi_q !== 8'hFF || hi_co !== 1'b1) begin
            errors++; $display("FAIL cas_full: got lo=%h hi=%h hco=%b expected lo=ff hi=ff hco=1", lo_q, hi_q, hi_co);
        end
        tick();
        checks++;
        if (lo_q !== 8'h00 || hi_q !== 8'h00) begin
            errors++; $display("FAIL cas_wrap: got lo=%h hi=%h expected lo=00 hi=00", lo_q, hi_q);
        end
    endtask

    task automatic test_mid_reset();
        r_clrn = 1'b1; r_en = 1'b0; r_mode = 3'b000;
        tick();
        checks++;
        if (r_q !== 8'h5A) begin errors++; $display("FAIL rv_reset: got %h expected %h", r_q, 8'h5A); end
        r_clrn = 1'b0; r_en = 1'b1; r_mode = 3'b110;
        tick();
        tick();
        checks++;
        if (r_q !== 8'h5C) begin errors++; $display("FAIL rv_count: got %h expected %h", r_q, 8'h5C); end
        r_clrn = 1'b1;
        tick();
        checks++;
        if (r_q !== 8'h5A) begin errors++; $display("FAIL rv_mid_clr: got %h expected %h", r_q, 8'h5A); end
        r_clrn = 1'b0;
        tick();
        checks++;
        if (r_q !== 8'h5B) begin errors++; $display("FAIL rv_resume1: got %h expected %h", r_q, 8'h5B); end
        tick();
        checks++;
        if (r_q !== 8'h5C) begin errors++; $display("FAIL rv_resume2: got %h expected %h", r_q, 8'h5C); end
    endtask

    initial begin
        clrn = 1'b1; en = 1'b0; mode = 3'b000; d = 8'h00; sin_l = 1'b0; sin_r = 1'b0;
        c_clrn = 1'b1; c_en = 1'b0; c_mode = 3'b000;
        r_clrn = 1'b1; r_en = 1'b0; r_mode = 3'b000;
        test_reset();
        test_reset_priority();
        test_load_hold();
        test_shifts();
        test_count_wrap();
        test_cascade();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/univ_shift_reg.md
Name: univ_shift_reg

Overview:
- Parametrised, multi-mode register: the next generation of the team's single-bit master-slave D flip-flop.
- Generalised to WIDTH bits, with clock enable, parallel load, left/right shift, rotate, and up/down count with carry/borrow.
- Lab datapath building block for register-file staging, serial links, and loop counters.
- Behavioural RTL with one edge-triggered register bank; no latches.

Parameters:
- WIDTH, 8, register width in bits; legal range is 2 or more.
- RESET_VALUE, 0, value loaded into q on reset; truncated to WIDTH bits.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- clrn  input  1  clear. Synchronous, active-high. When 1 at a rising clk edge, q <= RESET_VALUE.
- en  input  1  clock enable. When 0, q holds regardless of mode.
- mode  input  3  operation select (encoding in Behaviour).
- d  input  WIDTH  parallel load data.
- sin_l  input  1  serial input into the MSB on shift right.
- sin_r  input  1  serial input into the LSB on shift left.
- q  output  WIDTH  registered state.
- sout_l  output  1  q[WIDTH-1]; combinational from q.
- sout_r  output  1  q[0]; combinational from q.
- co  output  1  carry/borrow out; combinational.
- zero  output  1  1 when q == 0; combinational from q.

Behaviour:
- Reset: clrn=1 at a rising edge -> q=RESET_VALUE on the next cycle.
  - Overrides en and mode.
  - Outputs follow from q: with default RESET_VALUE, q=0, zero=1, sout_l=0, sout_r=0, co=0 unless the count-down condition applies.
  - Applies mid-operation with no residual state; there is no other internal state.
- Priority: clrn > en > mode.
- en=0 (and clrn=0): q holds.
- en=1: q updates at the rising edge per mode:
  - 000 HOLD: q <= q.
  - 001 LOAD: q <= d.
  - 010 SHL: q <= {q[WIDTH-2:0], sin_r}.
  - 011 SHR: q <= {sin_l, q[WIDTH-1:1]}.
  - 100 ROL: q <= {q[WIDTH-2:0], q[WIDTH-1]}.
  - 101 ROR: q <= {q[0], q[WIDTH-1:1]}.
  - 110 CNTUP: q <= q+1, modulo 2^WIDTH; all-ones wraps to 0.
  - 111 CNTDN: q <= q-1, modulo 2^WIDTH; 0 wraps to all-ones.
- Latency: 1 cycle from a sampled input to q. sout_l, sout_r and zero are valid in the same cycle as q.
- co = en & ((mode==110 & q==all-ones) | (mode==111 & q==0)).
  - Asserted in the cycle before the wrap, so counters cascade: connect co of the lower stage to en of the upper stage, both in the same mode.
  - co does not depend on clrn.
  - co=0 in all non-count modes.
- Shift behaviour:
  - The serial input not used by the current mode is ignored.
  - Shifted-out bit: sout_l before SHL, sout_r before SHR, sampled from current q.
- Mode changes take effect on the next edge; there is no pipeline or mode history.
- No X propagation is permitted from unused inputs.
- All arithmetic is unsigned and exactly WIDTH bits; no overflow flag beyond co.

Test Plan (WIDTH=8, RESET_VALUE=0 unless stated):
- Reset priority: LOAD d=8'hA5 with en=1, then clrn=1 with en=1, mode=001, d=8'hFF for one edge -> q=8'h00, zero=1. Release clrn and repeat the LOAD -> q=8'hFF.
- Load/hold/enable: LOAD 8'h3C; then mode=110 with en=0 for 3 edges -> q stays 8'h3C. Set mode=000 with en=1 -> q stays 8'h3C.
- Shifts:
  - q=8'h81, SHL with sin_r=1 -> 8'h03 (sout_l was 1 before the edge).
  - From 8'h81, SHR with sin_l=0 -> 8'h40.
  - ROL of 8'h81 -> 8'h03.
  - ROR of 8'h81 -> 8'hC0.
- Count wrap:
  - LOAD 8'hFE, CNTUP -> q=8'hFF with co=1 during that cycle; next edge -> q=8'h00, co=0, zero=1.
  - CNTDN from 8'h00 -> co=1, next q=8'hFF.
- Cascade: two instances chained via co->en, both CNTUP, starting from low=8'hFF, high=8'h00 -> after one edge low=8'h00, high=8'h01. Run 65535 edges from 0 -> all-ones on both.
- Reset mid-operation with RESET_VALUE=8'h5A: counting up, assert clrn for one edge -> q=8'h5A. Counting resumes next cycle: 8'h5B, then 8'h5C.
